// File: rtl/bist_compare_checker.sv
// Registered compare/verdict checker for the FIFO BIST read phase: masked data compare,
// sticky fail, saturating error count, first-failing-address capture and end-of-sweep verdict.
module bist_compare_checker #(
  parameter int SIZE   = 10,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              en_i,
  input  logic              last_i,
  input  logic [SIZE-1:0]   data_a_i,
  input  logic [SIZE-1:0]   data_b_i,
  input  logic [SIZE-1:0]   mask_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              pass_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              first_err_valid_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              done_o,
  output logic              result_ok_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              pass_q;
  logic              fail_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;
  logic              first_err_valid_q;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic              done_q;
  logic              result_ok_q;
  logic [SIZE-1:0]   diff_d;
  logic              match_d;

  // An X/Z bit under the mask makes the equality unknown; the if() below then
  // falls into the mismatch branch, so PASS is never driven to X.
  always_comb begin
    diff_d    = (data_a_i ^ data_b_i) & mask_i;
    match_d   = (diff_d == '0);
    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      pass_q            <= 1'b0;
      fail_q            <= 1'b0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      done_q            <= 1'b0;
      result_ok_q       <= 1'b0;
    end else if (start_i) begin
      state_q           <= RUN;
      pass_q            <= 1'b0;
      fail_q            <= 1'b0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      done_q            <= 1'b0;
      result_ok_q       <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (en_i) begin
            if (match_d) begin
              pass_q <= 1'b1;
              if (last_i) begin
                result_ok_q <= ~fail_q;
              end
            end else begin
              fail_q    <= 1'b1;
              err_cnt_q <= err_cnt_d;
              if (!first_err_valid_q) begin
                first_err_valid_q <= 1'b1;
                first_err_addr_q  <= addr_i;
              end
              if (last_i) begin
                result_ok_q <= 1'b0;
              end
            end
            if (last_i) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign pass_o            = pass_q;
  assign fail_o            = fail_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_addr_o  = first_err_addr_q;
  assign done_o            = done_q;
  assign result_ok_o       = result_ok_q;

endmodule

// File: tb/tb_bist_compare_checker.sv
// Directed self-checking bench for bist_compare_checker; a second instance with a
// 2-bit error counter exercises saturation.
module tb_bist_compare_checker;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       en;
  logic       last;
  logic [9:0] dataA;
  logic [9:0] dataB;
  logic [9:0] mask;
  logic [3:0] addr;

  logic       pass, fail, firstErrValid, done, resultOk;
  logic [7:0] errCnt;
  logic [3:0] firstErrAddr;
  logic       passS, failS, firstErrValidS, doneS, resultOkS;
  logic [1:0] errCntS;
  logic [3:0] firstErrAddrS;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_compare_checker #(.SIZE(10), .ADDR_W(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .en_i(en), .last_i(last),
    .data_a_i(dataA), .data_b_i(dataB), .mask_i(mask), .addr_i(addr),
    .pass_o(pass), .fail_o(fail), .err_cnt_o(errCnt),
    .first_err_valid_o(firstErrValid), .first_err_addr_o(firstErrAddr),
    .done_o(done), .result_ok_o(resultOk)
  );

  bist_compare_checker #(.SIZE(10), .ADDR_W(4), .CNT_W(2)) dutSat (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .en_i(en), .last_i(last),
    .data_a_i(dataA), .data_b_i(dataB), .mask_i(mask), .addr_i(addr),
    .pass_o(passS), .fail_o(failS), .err_cnt_o(errCntS),
    .first_err_valid_o(firstErrValidS), .first_err_addr_o(firstErrAddrS),
    .done_o(doneS), .result_ok_o(resultOkS)
  );

  // Drive one cycle of inputs, then let the edge pass and settle before checking.
  task automatic applyStimulus(input logic s, input logic e, input logic l,
                               input logic [9:0] a, input logic [9:0] b,
                               input logic [9:0] m, input logic [3:0] ad);
    start = s; en = e; last = l; dataA = a; dataB = b; mask = m; addr = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [9:0] d;
    logic       isErr;
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h001, 10'h002, 10'h3FF, 4'd5);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_cnt", errCnt, 0);
    checkOutput("rst_fev", firstErrValid, 0);
    checkOutput("rst_fea", firstErrAddr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ok", resultOk, 0);
    rstN = 1'b1;

    $display("[TB] EN while IDLE");
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h001, 10'h002, 10'h3FF, 4'd5);
    checkOutput("idle_pass", pass, 0);
    checkOutput("idle_fail", fail, 0);
    checkOutput("idle_cnt", errCnt, 0);
    checkOutput("idle_done", done, 0);

    $display("[TB] clean sweep");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    for (int i = 0; i < 16; i++) begin
      d = 10'(i * 37);
      applyStimulus(1'b0, 1'b1, (i == 15), d, d, 10'h3FF, 4'(i));
      checkOutput($sformatf("clean_pass%0d", i), pass, 1);
    end
    checkOutput("clean_done", done, 1);
    checkOutput("clean_ok", resultOk, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    checkOutput("clean_pass_after", pass, 0);
    checkOutput("clean_done_hold", done, 1);
    checkOutput("clean_ok_hold", resultOk, 1);
    checkOutput("clean_cnt", errCnt, 0);
    checkOutput("clean_fail", fail, 0);

    $display("[TB] sweep with errors at addr 3 and 9");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    checkOutput("err_start_done", done, 0);
    checkOutput("err_start_ok", resultOk, 0);
    for (int i = 0; i < 16; i++) begin
      d = 10'(i * 41 + 7);
      isErr = (i == 3) || (i == 9);
      applyStimulus(1'b0, 1'b1, (i == 15), d, d ^ {9'h0, isErr}, 10'h3FF, 4'(i));
      checkOutput($sformatf("err_pass%0d", i), pass, {31'h0, !isErr});
      checkOutput($sformatf("err_fail%0d", i), fail, {31'h0, (i >= 3)});
    end
    checkOutput("err_cnt", errCnt, 2);
    checkOutput("err_fev", firstErrValid, 1);
    checkOutput("err_fea", firstErrAddr, 3);
    checkOutput("err_done", done, 1);
    checkOutput("err_ok", resultOk, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h000, 10'h3FF, 10'h3FF, 4'd12);
    checkOutput("done_en_pass", pass, 0);
    checkOutput("done_en_cnt", errCnt, 2);
    checkOutput("done_en_fea", firstErrAddr, 3);

    $display("[TB] mask");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3F0, 10'h3F0, 4'd1);
    checkOutput("mask_partial_pass", pass, 1);
    checkOutput("mask_partial_fail", fail, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3F0, 10'h3FF, 4'd2);
    checkOutput("mask_full_pass", pass, 0);
    checkOutput("mask_full_fail", fail, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h155, 10'h2AA, 10'h000, 4'd3);
    checkOutput("mask_zero_pass", pass, 1);

    $display("[TB] saturation");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h00F, 10'h0F0, 10'h3FF, 4'(i + 6));
    end
    checkOutput("sat_cnt", errCntS, 3);
    checkOutput("sat_wide_cnt", errCnt, 5);
    checkOutput("sat_fea", firstErrAddrS, 6);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h00F, 10'h0F0, 10'h3FF, 4'd11);
    checkOutput("sat_hold_cnt", errCntS, 3);
    checkOutput("sat_done", doneS, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    checkOutput("sat_clr_cnt", errCntS, 0);
    checkOutput("sat_clr_done", doneS, 0);

    $display("[TB] START with EN, then single-entry sweep");
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h001, 10'h002, 10'h3FF, 4'd4);
    checkOutput("se_pass", pass, 0);
    checkOutput("se_fail", fail, 0);
    checkOutput("se_cnt", errCnt, 0);
    checkOutput("se_done", done, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h123, 10'h123, 10'h3FF, 4'd7);
    checkOutput("single_pass", pass, 1);
    checkOutput("single_done", done, 1);
    checkOutput("single_ok", resultOk, 1);

    $display("[TB] unknown data bit under mask");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 10'h3FF, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, {9'h0, 1'bx}, 10'h3FF, 10'h3FF, 4'd8);
    checkOutput("x_pass", pass, 0);
    checkOutput("x_fail", fail, 1);
    checkOutput("x_fea", firstErrAddr, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
